// File: rtl/song_writer.sv
// song_writer: captures live key presses as packed note/rest entries for the
// 128-entry user-song RAM, then fills the unused tail of the RAM with zero-length rests.
module song_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        record,
  input  logic        beat,
  input  logic [5:0]  key_note,
  output logic        write_enable,
  output logic [6:0]  write_address,
  output logic [15:0] write_payload,
  output logic [7:0]  entries_written,
  output logic        full,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    NOTE  = 3'd2,
    REST  = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [8:0]  DUR_MAX     = 9'd511;
  localparam logic [7:0]  DEPTH       = 8'd128;
  localparam logic [6:0]  LAST_ADDR   = 7'd127;
  localparam logic [15:0] CLEAR_ENTRY = 16'h8000;

  state_t      state, state_next;
  logic        record_q;
  logic [5:0]  note, note_next;
  logic [8:0]  dur, dur_next;
  logic [7:0]  count_next;
  logic        full_next;
  logic [6:0]  clear_ptr, clear_ptr_next;
  logic        we_next;
  logic [6:0]  addr_next;
  logic [15:0] payload_next;
  logic        busy_next;

  logic        record_rise;
  logic [8:0]  dur_eff;
  logic [8:0]  note_dur;
  logic [7:0]  count_inc;

  // A beat landing in the same cycle as a key change belongs to the entry being closed.
  assign record_rise = record & ~record_q;
  assign dur_eff     = (beat && (dur != DUR_MAX)) ? (dur + 9'd1) : dur;
  assign note_dur    = (dur_eff == 9'd0) ? 9'd1 : dur_eff;
  assign count_inc   = entries_written + 8'd1;

  // Next-state, entry packing and write strobe generation.
  always_comb begin
    state_next     = state;
    note_next      = note;
    dur_next       = dur;
    count_next     = entries_written;
    full_next      = full;
    clear_ptr_next = clear_ptr;
    we_next        = 1'b0;
    addr_next      = write_address;
    payload_next   = write_payload;

    if (record_rise) begin
      // A new recording always wins, even over a pending entry or a running clear.
      state_next = ARM;
      count_next = 8'd0;
      full_next  = 1'b0;
      dur_next   = 9'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state_next = state;
        end

        ARM: begin
          // Leading silence is never recorded.
          if (!record) begin
            state_next     = CLEAR;
            clear_ptr_next = 7'd0;
          end else if (key_note != 6'd0) begin
            note_next  = key_note;
            dur_next   = 9'd0;
            state_next = NOTE;
          end
        end

        NOTE: begin
          if (!record || (key_note != note)) begin
            we_next      = 1'b1;
            addr_next    = entries_written[6:0];
            payload_next = {1'b0, note, note_dur};
            count_next   = count_inc;
            dur_next     = 9'd0;
            if (count_inc == DEPTH) begin
              full_next  = 1'b1;
              state_next = DONE;
            end else if (!record) begin
              state_next     = CLEAR;
              clear_ptr_next = count_inc[6:0];
            end else if (key_note != 6'd0) begin
              note_next  = key_note;
              state_next = NOTE;
            end else begin
              state_next = REST;
            end
          end else begin
            dur_next = dur_eff;
          end
        end

        REST: begin
          if (!record) begin
            // The trailing rest is dropped.
            state_next     = CLEAR;
            clear_ptr_next = entries_written[6:0];
            dur_next       = 9'd0;
          end else if (key_note != 6'd0) begin
            note_next = key_note;
            dur_next  = 9'd0;
            if (dur_eff != 9'd0) begin
              we_next      = 1'b1;
              addr_next    = entries_written[6:0];
              payload_next = {1'b1, 6'd0, dur_eff};
              count_next   = count_inc;
            end
            if ((dur_eff != 9'd0) && (count_inc == DEPTH)) begin
              full_next  = 1'b1;
              state_next = DONE;
            end else begin
              state_next = NOTE;
            end
          end else begin
            dur_next = dur_eff;
          end
        end

        CLEAR: begin
          we_next      = 1'b1;
          addr_next    = clear_ptr;
          payload_next = CLEAR_ENTRY;
          if (clear_ptr == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            clear_ptr_next = clear_ptr + 7'd1;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = !((state_next == IDLE) || (state_next == DONE));
  end

  // State and registered outputs; reset aborts any recording or clear immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      record_q        <= 1'b0;
      note            <= 6'd0;
      dur             <= 9'd0;
      entries_written <= 8'd0;
      full            <= 1'b0;
      clear_ptr       <= 7'd0;
      write_enable    <= 1'b0;
      write_address   <= 7'd0;
      write_payload   <= 16'd0;
      busy            <= 1'b0;
    end else begin
      state           <= state_next;
      record_q        <= record;
      note            <= note_next;
      dur             <= dur_next;
      entries_written <= count_next;
      full            <= full_next;
      clear_ptr       <= clear_ptr_next;
      write_enable    <= we_next;
      write_address   <= addr_next;
      write_payload   <= payload_next;
      busy            <= busy_next;
    end
  end

endmodule

// File: tb/tb_song_writer.sv
// Bench for song_writer: key/beat sessions described as segments (key value,
// beat count, beat-on-change flag); expected RAM writes are derived from those
// segments and compared against the observed write stream.
module tb_song_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        record;
  logic        beat;
  logic [5:0]  key_note;
  logic        write_enable;
  logic [6:0]  write_address;
  logic [15:0] write_payload;
  logic [7:0]  entries_written;
  logic        full;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [6:0]  log_addr[$];
  logic [15:0] log_data[$];
  logic [6:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_count;

  int seg_key[$];
  int seg_n[$];
  int seg_co[$];

  song_writer dut (
    .clk             (clk),
    .reset           (reset),
    .record          (record),
    .beat            (beat),
    .key_note        (key_note),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_payload   (write_payload),
    .entries_written (entries_written),
    .full            (full),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (write_enable === 1'b1) begin
      log_addr.push_back(write_address);
      log_data.push_back(write_payload);
    end
  endtask

  task automatic add_seg(input int k, input int n, input int co);
    seg_key.push_back(k);
    seg_n.push_back(n);
    seg_co.push_back(co);
  endtask

  task automatic clear_segs();
    seg_key.delete();
    seg_n.delete();
    seg_co.delete();
  endtask

  // Expected writes: every held note becomes an entry (length at least 1, at most 511),
  // rests count only between notes and only if non-empty, then the RAM tail is cleared.
  function automatic void build_expected(input int clear_limit);
    int count;
    int started;
    int d;
    int nclr;
    logic [5:0] kk;
    logic [8:0] dd;
    exp_addr.delete();
    exp_data.delete();
    count   = 0;
    started = 0;
    for (int i = 0; i < seg_key.size() && count < 128; i++) begin
      d = seg_n[i] + seg_co[i];
      if (d > 511) d = 511;
      if (seg_key[i] != 0) begin
        started = 1;
        if (d == 0) d = 1;
        kk = 6'(seg_key[i]);
        dd = 9'(d);
        exp_addr.push_back(7'(count));
        exp_data.push_back({1'b0, kk, dd});
        count++;
      end else if (started != 0 && i != seg_key.size() - 1 && d > 0) begin
        dd = 9'(d);
        exp_addr.push_back(7'(count));
        exp_data.push_back({1'b1, 6'd0, dd});
        count++;
      end
    end
    exp_count = count;
    if (count < 128) begin
      nclr = 128 - count;
      if (clear_limit >= 0 && clear_limit < nclr) nclr = clear_limit;
      for (int a = 0; a < nclr; a++) begin
        exp_addr.push_back(7'(count + a));
        exp_data.push_back(16'h8000);
      end
    end
  endfunction

  task automatic drive_segments();
    for (int i = 0; i < seg_key.size(); i++) begin
      key_note = 6'(seg_key[i]);
      beat     = (i > 0) ? (seg_co[i-1] != 0) : 1'b0;
      tick();
      beat = 1'b0;
      for (int j = 0; j < seg_n[i]; j++) begin
        repeat (1 + $urandom_range(1, 0)) tick();
        beat = 1'b1;
        tick();
        beat = 1'b0;
      end
    end
  endtask

  task automatic compare_log(input string name);
    int n;
    check({name, "/num_writes"}, log_data.size(), exp_data.size());
    n = (log_data.size() < exp_data.size()) ? log_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s/addr[%0d]", name, i), 32'(log_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s/data[%0d]", name, i), 32'(log_data[i]), 32'(exp_data[i]));
    end
  endtask

  // Full session: record rise, segments, record fall, then either wait for the
  // clear to finish or restart after restart_after clear cycles.
  task automatic run_recording(input string name, input int restart_after);
    int g;
    log_addr.delete();
    log_data.delete();
    build_expected(restart_after);
    record   = 1'b1;
    key_note = 6'd0;
    beat     = 1'b0;
    tick();
    check({name, "/busy_after_rise"}, 32'(busy), 32'd1);
    drive_segments();
    record = 1'b0;
    beat   = (seg_co[seg_co.size()-1] != 0);
    tick();
    beat = 1'b0;
    if (restart_after >= 0) begin
      repeat (restart_after) tick();
      record = 1'b1;
      tick();
      compare_log(name);
      check({name, "/restart_count"}, 32'(entries_written), 32'd0);
      check({name, "/restart_full"},  32'(full), 32'd0);
      check({name, "/restart_busy"},  32'(busy), 32'd1);
    end else begin
      g = 0;
      while (busy === 1'b1 && g < 400) begin
        tick();
        g++;
      end
      check({name, "/finish_in_time"}, 32'(g < 400), 32'd1);
      tick();
      check({name, "/idle_we"},   32'(write_enable), 32'd0);
      check({name, "/idle_busy"}, 32'(busy), 32'd0);
      compare_log(name);
      check({name, "/entries_written"}, 32'(entries_written), 32'(exp_count));
      check({name, "/full"}, 32'(full), 32'(exp_count == 128));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "/we"},      32'(write_enable), 32'd0);
    check({name, "/addr"},    32'(write_address), 32'd0);
    check({name, "/payload"}, 32'(write_payload), 32'd0);
    check({name, "/count"},   32'(entries_written), 32'd0);
    check({name, "/full"},    32'(full), 32'd0);
    check({name, "/busy"},    32'(busy), 32'd0);
  endtask

  // After releasing reset the block must sit idle: key activity alone writes nothing.
  task automatic release_and_check_idle(input string name);
    record   = 1'b0;
    key_note = 6'd0;
    beat     = 1'b0;
    #2;
    reset = 1'b1;
    log_addr.delete();
    log_data.delete();
    key_note = 6'd3; tick();
    beat = 1'b1;     tick();
    beat = 1'b0;
    key_note = 6'd4; tick();
    key_note = 6'd0; tick();
    check({name, "/idle_no_writes"}, log_data.size(), 0);
    check({name, "/idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nseg;
    int prev;
    int k;

    reset    = 1'b0;
    record   = 1'b0;
    beat     = 1'b0;
    key_note = 6'd0;
    #1;
    check_reset_outputs("reset_initial");
    repeat (3) tick();
    check_reset_outputs("reset_held");
    #2;
    reset = 1'b1;
    tick();

    // Note 12 x10 beats, rest 4, note 20 x3, then clear to the end.
    clear_segs();
    add_seg(12, 10, 0); add_seg(0, 4, 0); add_seg(20, 3, 0);
    run_recording("basic", -1);
    check("basic/entry0", 32'(log_data[0]), 32'h180A);
    check("basic/entry1", 32'(log_data[1]), 32'h8004);
    check("basic/entry2", 32'(log_data[2]), 32'h2803);
    check("basic/last_clear", 32'(log_addr[log_addr.size()-1]), 32'd127);

    // Direct key change with no beat in between: minimum length of 1.
    clear_segs();
    add_seg(5, 0, 0); add_seg(7, 2, 0);
    run_recording("direct_change", -1);
    check("direct_change/entry0", 32'(log_data[0]), 32'h0A01);

    // Beat coincident with release adds to the closing note.
    clear_segs();
    add_seg(9, 6, 1); add_seg(0, 3, 0); add_seg(11, 1, 0);
    run_recording("coincident_beat", -1);
    check("coincident_beat/entry0", 32'(log_data[0]), 32'h1207);

    // Long hold saturates at 511.
    clear_segs();
    add_seg(33, 600, 0);
    run_recording("saturate", -1);
    check("saturate/entry0", 32'(log_data[0]), 32'h43FF);

    // Leading silence skipped, trailing rest discarded.
    clear_segs();
    add_seg(0, 20, 0); add_seg(14, 2, 0); add_seg(0, 5, 0);
    run_recording("silence_edges", -1);
    check("silence_edges/entry0", 32'(log_data[0]), 32'h1C02);
    check("silence_edges/clear_start", 32'(log_addr[1]), 32'd1);

    // 130 alternating notes: full after 128, no clear, later keys ignored.
    clear_segs();
    for (int i = 0; i < 130; i++) add_seg((i % 2) + 1, 0, 0);
    run_recording("fill", -1);

    // Restart during clear abandons it; the new session begins empty.
    clear_segs();
    add_seg(3, 2, 0); add_seg(0, 1, 0); add_seg(4, 1, 0);
    run_recording("restart", 5);
    log_addr.delete();
    log_data.delete();
    record = 1'b0;
    tick();
    for (int g = 0; g < 400 && busy === 1'b1; g++) tick();
    check("restart/full_clear_writes", log_data.size(), 128);
    check("restart/first_clear_addr", 32'(log_addr[0]), 32'd0);

    // Randomized sessions.
    for (int s = 0; s < 6; s++) begin
      clear_segs();
      nseg = 1 + $urandom_range(9, 0);
      prev = -1;
      for (int i = 0; i < nseg; i++) begin
        if (prev != 0 && $urandom_range(2, 0) == 0) begin
          k = 0;
        end else begin
          do k = 1 + $urandom_range(62, 0); while (k == prev);
        end
        add_seg(k, ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(19, 0),
                ($urandom_range(3, 0) == 0) ? 1 : 0);
        prev = k;
      end
      run_recording($sformatf("random%0d", s), -1);
    end

    // Reset while a note entry is being written.
    record = 1'b1; key_note = 6'd0; tick();
    key_note = 6'd10; tick();
    beat = 1'b1; tick(); beat = 1'b0; tick();
    key_note = 6'd11; tick();
    check("mid_note/write_seen", 32'(write_enable), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_note_reset");
    release_and_check_idle("mid_note");

    // Reset while clear writes are in progress.
    record = 1'b1; key_note = 6'd0; tick();
    key_note = 6'd8; tick();
    beat = 1'b1; tick(); beat = 1'b0; tick();
    record = 1'b0; tick();
    tick(); tick();
    check("mid_clear/write_seen", 32'(write_enable), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_clear_reset");
    release_and_check_idle("mid_clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/song_writer.md
# song_writer

Records live notes from the MCU key interface into the 128-entry user-song RAM (song slot 3), producing the 16-bit entry stream that the song player later reads back. Sits between the MCU/keyboard front end and port A of the user-song RAM. It measures note-hold and silence lengths in beats (48ths of a second), packs them as note or rest entries, and clears the unused tail of the RAM when recording stops.

## Interface
Parameters: none. Depth is fixed at 128 entries (7-bit address); entry width is fixed at 16 bits.

- clk  in  1  system clock; one clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- record  in  1  level; 0→1 starts a new recording, 1→0 ends it
- beat  in  1  one-cycle pulse, 48 Hz duration tick
- key_note  in  6  currently pressed note; 6'd0 = no key
- write_enable  out  1  one-cycle RAM write strobe (port A wea)
- write_address  out  7  RAM port A address
- write_payload  out  16  entry: [15] rest flag, [14:9] note, [8:0] duration in beats
- entries_written  out  8  number of note/rest entries recorded, 0..128
- full  out  1  128 entries recorded; held until next record rise
- busy  out  1  high in every state except IDLE and DONE

## Operation
- States: IDLE, ARM, NOTE, REST, CLEAR, DONE.
- IDLE/DONE: record 0→1 (edge detected against registered record) → ARM, entries_written=0, full=0.
- ARM: leading silence is not recorded. When key_note≠0: latch note, dur=0 → NOTE. record low → CLEAR from address 0.
- NOTE: each beat increments dur, saturating at 511 (no split). key_note ≠ latched note → write {1'b0, note, max(dur_eff,1)}. Then key_note≠0: latch new note, dur=0, stay in NOTE. key_note=0: dur=0 → REST.
- REST: each beat increments dur, saturating at 511. key_note≠0 → if dur_eff>0 write {1'b1, 6'd0, dur_eff}, else no write. Then latch note, dur=0 → NOTE.
- dur_eff = dur + beat (saturating). A beat that arrives in the same cycle as the key change counts toward the entry being closed.
- record 1→0 in NOTE: write the pending note entry, then → CLEAR. In REST: discard the trailing rest → CLEAR.
- Every write uses write_address = entries_written[6:0], then increments entries_written.
- When entries_written reaches 128: full=1 → DONE immediately. No clear. Further keys are ignored.
- CLEAR: write {1'b1, 6'd0, 9'd0} to addresses entries_written..127, one per cycle, with a 7-bit clear pointer. entries_written does not change. After address 127 → DONE.
- record 0→1 during CLEAR/DONE: restart (→ ARM). The clear is abandoned.
- record 0→1 and key change in the same cycle: the restart wins and the pending entry is discarded.

## Timing
- All outputs are registered. Reset values: write_enable=0, write_address=0, write_payload=0, entries_written=0, full=0, busy=0; state=IDLE, dur=0.
- Inputs are sampled at a rising edge k. The resulting write_enable is high for exactly cycle k+1, with address and payload valid in the same cycle.
- Back-to-back writes (closing entry, then immediate full / CLEAR writes) may occur on consecutive cycles. There is at most one write per cycle.
- CLEAR of n remaining addresses takes n cycles. busy drops the cycle after the last clear write.
- record rise → busy high the next cycle.
- An asserted reset mid-operation aborts immediately. RAM contents already written are left as-is.

## Test plan
- Record rise, key 6'd12 held for 10 beats, release, 4 beats silent, key 6'd20 held for 3 beats, record fall → writes: addr0 = 16'h180A (note 12, dur 10); addr1 = rest dur 4 = 16'h8004; addr2 = note 20 dur 3 = 16'h2803; then addr3..127 = 16'h8000; busy low after last; entries_written=3.
- Key 6'd5 changes directly to 6'd7 with no beat between → addr0 = note 5, dur 1 (minimum enforced); note 7 entry starts with dur 0.
- Beat pulse in the same cycle as release of a note with dur 6 → written duration is 7.
- Hold a note for 600 beats → duration saturates, entry written as 511. 128 alternating notes → full=1, DONE, no CLEAR writes, further keys produce no writes.
- Leading silence of 20 beats before the first key → no rest entry at addr0. Record fall during REST → trailing rest is not written.
- Reset asserted (0) mid-NOTE and mid-CLEAR → write_enable drops immediately, all outputs return to reset values, state is IDLE.
